data_mem_responder: RTL and testbench

Data-memory responder on the memory-stage side of the pipelined datapath. The memory stage issues load/store requests carrying an ALU-computed address and the register-read store data. This block is the responder at the far end of that interface. It accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, commits stores, returns load data, and pulses a completion strobe that the memory stage uses to release its pipeline latch.

---
 rtl/data_mem_responder_pkg.sv | 20 ++
 rtl/data_mem_responder_dmem_array.sv | 31 +++
 rtl/data_mem_responder.sv | 143 ++++++++++++++
 tb/tb_data_mem_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// The optional out-of-range check is enabled with the DMEM_RANGE_CHECK_EN macro.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 2;

    // Word-index width for a power-of-two depth.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port Depth x Width word storage: synchronous write, combinational read,
// asynchronous clear of every word on reset.
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we_i,
    input  logic [idx_width(DEPTH)-1:0] idx_i,
    input  logic [WIDTH-1:0]            wdata_i,
    output logic [WIDTH-1:0]            rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, LATENCY wait states, one-cycle rvalid.
// Define DMEM_RANGE_CHECK_EN to reject addresses beyond the array instead of wrapping.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             ready,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             err
);

    localparam int IW       = idx_width(DEPTH);
    localparam int CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int CNT_INIT = (LATENCY > 0) ? LATENCY - 1 : 0;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             cur_we;
    logic [WIDTH-1:0] cur_addr;
    logic [WIDTH-1:0] cur_wdata;
    logic             req_err;
    logic             enter_resp;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    // With zero latency RESP is entered straight from IDLE, so the live inputs
    // are the request; otherwise the captured copy is.
    assign cur_we    = (state_q == ST_IDLE) ? we    : we_q;
    assign cur_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;

`ifdef DMEM_RANGE_CHECK_EN
    assign req_err = (cur_addr[1:0] != 2'b00) || (|cur_addr[WIDTH-1:IW+2]);
`else
    logic unused_upper_addr;
    assign unused_upper_addr = ^cur_addr[WIDTH-1:IW+2];
    assign req_err = (cur_addr[1:0] != 2'b00);
`endif

    dmem_array #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (mem_we),
        .idx_i  (cur_addr[IW+1:2]),
        .wdata_i(cur_wdata),
        .rdata_o(mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CW'(CNT_INIT);
                    if (LATENCY > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Commit and read happen on the single edge that enters RESP.
        if (enter_resp) begin
            err_d   = req_err;
            mem_we  = cur_we && !req_err;
            rdata_d = (!cur_we && !req_err) ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign rvalid = (state_q == ST_RESP);
    assign rdata  = rdata_q;
    assign err    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: handshake timing, stores, loads, errors, reset abort.
// Expectations for the 0x400 store follow DMEM_RANGE_CHECK_EN.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(
        .WIDTH  (32),
        .DEPTH  (256),
        .LATENCY(LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready),
        .rvalid(rvalid),
        .rdata (rdata),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Issue one request starting at a negedge; checks the full handshake timeline
    // and returns the response captured in the RESP cycle.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, output logic [31:0] rd, output logic e,
                          output int n_wait);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        n_wait = 0;
        while (ready !== 1'b1 && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        check("accept_ready", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("wait_rvalid", {31'd0, rvalid}, 32'd0);
            check("wait_ready", {31'd0, ready}, 32'd0);
        end
        @(negedge clk);
        check("resp_rvalid", {31'd0, rvalid}, 32'd1);
        check("resp_ready", {31'd0, ready}, 32'd0);
        rd = rdata;
        e  = err;
        @(negedge clk);
        check("idle_rvalid", {31'd0, rvalid}, 32'd0);
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_rdata", rdata, 32'd0);
        check("idle_err", {31'd0, err}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          nw;

        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // Store then load back.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, e, nw);
        check("st10_err", {31'd0, e}, 32'd0);
        check("st10_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0, rd, e, nw);
        check("ld10_rdata", rd, 32'hDEADBEEF);
        check("ld10_err", {31'd0, e}, 32'd0);

        // Unwritten top word.
        do_req(1'b0, 32'h3FC, 32'h0, 1'b0, rd, e, nw);
        check("ld3fc_rdata", rd, 32'h0);
        check("ld3fc_err", {31'd0, e}, 32'd0);

        // Misaligned store must not touch word 0x10 (index 4).
        do_req(1'b1, 32'h13, 32'h12345678, 1'b0, rd, e, nw);
        check("st13_err", {31'd0, e}, 32'd1);
        check("st13_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0, rd, e, nw);
        check("ld10_after_mis", rd, 32'hDEADBEEF);
        check("ld10_after_mis_err", {31'd0, e}, 32'd0);

        // Misaligned load.
        do_req(1'b0, 32'h12, 32'h0, 1'b0, rd, e, nw);
        check("ld12_err", {31'd0, e}, 32'd1);
        check("ld12_rdata", rd, 32'd0);

        // req held high: second request accepted in the IDLE cycle right after RESP.
        do_req(1'b1, 32'h44, 32'hA5A5A5A5, 1'b1, rd, e, nw);
        check("held_st_err", {31'd0, e}, 32'd0);
        do_req(1'b0, 32'h44, 32'h0, 1'b0, rd, e, nw);
        check("held_second_wait", nw, 32'd0);
        check("held_ld_rdata", rd, 32'hA5A5A5A5);

        // Reset during WAIT of a store to 0x20 aborts it.
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'h55AA55AA;
        check("abort_start_ready", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("abort_in_wait", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_rst_ready", {31'd0, ready}, 32'd1);
        check("abort_rst_rvalid", {31'd0, rvalid}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_rvalid", {31'd0, rvalid}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_post_rvalid", {31'd0, rvalid}, 32'd0);
            check("abort_post_ready", {31'd0, ready}, 32'd1);
        end
        do_req(1'b0, 32'h20, 32'h0, 1'b0, rd, e, nw);
        check("ld20_rdata", rd, 32'd0);
        check("ld20_err", {31'd0, e}, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 1'b0, rd, e, nw);
        check("ld10_after_rst", rd, 32'd0);

        // Address beyond the array.
        do_req(1'b1, 32'h400, 32'hCAFEF00D, 1'b0, rd, e, nw);
        do_req(1'b0, 32'h0, 32'h0, 1'b0, rd, e, nw);
`ifdef DMEM_RANGE_CHECK_EN
        check("ld0_after_oor", rd, 32'd0);
`else
        check("ld0_after_wrap", rd, 32'hCAFEF00D);
`endif
        check("ld0_err", {31'd0, e}, 32'd0);
        do_req(1'b1, 32'h400, 32'h0BADF00D, 1'b0, rd, e, nw);
`ifdef DMEM_RANGE_CHECK_EN
        check("st400_err", {31'd0, e}, 32'd1);
`else
        check("st400_err", {31'd0, e}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
